// File: rtl/mdu_pkg.sv
// Shared constants and types for the multi-cycle multiply/divide unit.
// Divider presence is selected by the MDU_DIV_EN macro in the top and sub-module.
package mdu_pkg;

  localparam int WIDTH = 16;

  localparam logic [1:0] OP_MULLO = 2'b00;
  localparam logic [1:0] OP_MULHI = 2'b01;
  localparam logic [1:0] OP_DIVQ  = 2'b10;
  localparam logic [1:0] OP_DIVR  = 2'b11;

  localparam logic [WIDTH-1:0] DIV0_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic isDivOp(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the register-file read ports and the multiply/divide unit.
// The master issues operands and receives the write-back result.
interface mul_div_unit_if;
  import mdu_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [3:0]       rd_in;
  logic             busy;
  logic             done;
  logic             wr;
  logic [WIDTH-1:0] result;
  logic [3:0]       rd_out;
  logic             err;

  modport master (
    output start, op, rs_data, rt_data, rd_in,
    input  busy, done, wr, result, rd_out, err
  );

  modport slave (
    input  start, op, rs_data, rt_data, rd_in,
    output busy, done, wr, result, rd_out, err
  );

endinterface

// File: rtl/mdu_divstep.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
// Only instantiated when MDU_DIV_EN is defined.
module mdu_divstep
  import mdu_pkg::*;
(
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shifted;
  logic [WIDTH+1:0] w_diff;

  // A set top bit of the difference means the trial subtraction went negative.
  assign w_shifted = {i_rem, i_bit};
  assign w_diff    = w_shifted - {2'b00, i_divisor};
  assign o_qbit    = ~w_diff[WIDTH+1];
  assign o_rem     = o_qbit ? w_diff[WIDTH:0] : w_shifted[WIDTH:0];

endmodule

// File: rtl/mul_div_unit.sv
// Bit-serial unsigned multiply/divide unit feeding register-file write-back.
// Define MDU_DIV_EN to build the restoring divider; otherwise divide ops report err.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_hiSel;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_low;
  logic [WIDTH-1:0] r_addend;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_count;
  logic [3:0]       r_rdPend;
  logic [3:0]       r_rdOut;
  logic             r_err;

  logic             w_accept;
  logic             w_lastIter;
  logic             w_shortPath;
  logic [WIDTH-1:0] w_shortResult;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_mulSel;
  logic [WIDTH:0]   w_nextAcc;
  logic [WIDTH-1:0] w_nextLow;

  assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
  assign w_lastIter = (r_state == RUN) && (r_count == 4'd0);

`ifdef MDU_DIV_EN
  logic             r_isDiv;
  logic [WIDTH:0]   w_divRem;
  logic             w_divQbit;

  mdu_divstep u_divstep (
    .i_rem     (r_acc),
    .i_bit     (r_low[WIDTH-1]),
    .i_divisor (r_addend),
    .o_rem     (w_divRem),
    .o_qbit    (w_divQbit)
  );

  assign w_shortPath   = isDivOp(bus.op) && (bus.rt_data == '0);
  assign w_shortResult = (bus.op == OP_DIVQ) ? DIV0_QUOT : bus.rs_data;
`else
  assign w_shortPath   = isDivOp(bus.op);
  assign w_shortResult = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) w_nextState = w_shortPath ? DONE : RUN;
        else           w_nextState = IDLE;
      end
      RUN:     if (r_count == 4'd0) w_nextState = DONE;
      default: w_nextState = IDLE;
    endcase
  end

  // r_acc/r_low hold {product high, multiplier} for multiply and {remainder, dividend->quotient} for divide.
  always_comb begin
    w_mulSum  = r_acc + {1'b0, r_addend};
    w_mulSel  = r_low[0] ? w_mulSum : r_acc;
    w_nextAcc = {1'b0, w_mulSel[WIDTH:1]};
    w_nextLow = {w_mulSel[0], r_low[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    if (r_isDiv) begin
      w_nextAcc = w_divRem;
      w_nextLow = {r_low[WIDTH-2:0], w_divQbit};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hiSel  <= 1'b0;
      r_acc    <= '0;
      r_low    <= '0;
      r_addend <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_rdPend <= '0;
      r_rdOut  <= '0;
      r_err    <= 1'b0;
`ifdef MDU_DIV_EN
      r_isDiv  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_hiSel  <= bus.op[0];
      r_acc    <= '0;
      r_count  <= 4'(WIDTH - 1);
      r_rdPend <= bus.rd_in;
`ifdef MDU_DIV_EN
      r_isDiv  <= isDivOp(bus.op);
`endif
      if (isDivOp(bus.op)) begin
        r_addend <= bus.rt_data;
        r_low    <= bus.rs_data;
      end else begin
        r_addend <= bus.rs_data;
        r_low    <= bus.rt_data;
      end
      if (w_shortPath) begin
        r_result <= w_shortResult;
        r_err    <= 1'b1;
        r_rdOut  <= bus.rd_in;
      end
    end else if (r_state == RUN) begin
      r_acc   <= w_nextAcc;
      r_low   <= w_nextLow;
      r_count <= r_count - 4'd1;
      if (w_lastIter) begin
        r_result <= r_hiSel ? w_nextAcc[WIDTH-1:0] : w_nextLow;
        r_err    <= 1'b0;
        r_rdOut  <= r_rdPend;
      end
    end
  end

  assign bus.busy   = (r_state == RUN);
  assign bus.done   = (r_state == DONE);
  assign bus.wr     = (r_state == DONE);
  assign bus.err    = (r_state == DONE) && r_err;
  assign bus.result = r_result;
  assign bus.rd_out = r_rdOut;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: cycle-level reference model plus directed literal cases.
// Expectations for divide ops follow whether MDU_DIV_EN is defined.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_unit_if bus();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int totalCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference result straight from arithmetic; shortP marks ops that finish without iterating.
  function automatic void refOp(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] res, output logic er, output logic shortP);
    logic [31:0] prod;
    prod   = {16'h0, a} * {16'h0, b};
    res    = '0;
    er     = 1'b0;
    shortP = 1'b0;
    case (op)
      OP_MULLO: res = prod[15:0];
      OP_MULHI: res = prod[31:16];
      default: begin
`ifdef MDU_DIV_EN
        if (b == 16'h0) begin
          er = 1'b1; shortP = 1'b1;
          res = (op == OP_DIVQ) ? 16'hFFFF : a;
        end else begin
          res = (op == OP_DIVQ) ? a / b : a % b;
        end
`else
        er = 1'b1; shortP = 1'b1; res = 16'h0;
`endif
      end
    endcase
  endfunction

  logic        smpStart, smpRst;
  logic [1:0]  smpOp;
  logic [15:0] smpA, smpB;
  logic [3:0]  smpRd;

  initial begin
    forever begin
      @(posedge clk);
      smpStart = bus.start;
      smpOp    = bus.op;
      smpA     = bus.rs_data;
      smpB     = bus.rt_data;
      smpRd    = bus.rd_in;
      smpRst   = rst;
    end
  end

  // Model: an accepted op either finishes immediately or 16 edges later; outputs are compared every cycle.
  initial begin : modelCompare
    int          mRunLeft;
    logic        mDoneNow, mErr, pendErr, er, sp;
    logic [15:0] mResult, pendResult, r;
    logic [3:0]  mRd, pendRd;
    mRunLeft = 0; mDoneNow = 0; mErr = 0; mResult = 0; mRd = 0;
    pendErr = 0; pendResult = 0; pendRd = 0;
    forever begin
      @(negedge clk);
      if (rst || smpRst) begin
        mRunLeft = 0; mDoneNow = 0; mErr = 0; mResult = 0; mRd = 0;
      end else begin
        mDoneNow = 0;
        if (mRunLeft > 0) begin
          mRunLeft--;
          if (mRunLeft == 0) begin
            mDoneNow = 1; mResult = pendResult; mRd = pendRd; mErr = pendErr;
          end
        end else if (smpStart) begin
          refOp(smpOp, smpA, smpB, r, er, sp);
          pendResult = r; pendRd = smpRd; pendErr = er;
          if (sp) begin
            mDoneNow = 1; mResult = r; mRd = smpRd; mErr = er;
          end else begin
            mRunLeft = 16;
          end
        end
      end
      checkOutput("busy",   bus.busy,   mRunLeft > 0);
      checkOutput("done",   bus.done,   mDoneNow);
      checkOutput("wr",     bus.wr,     mDoneNow);
      checkOutput("err",    bus.err,    mDoneNow && mErr);
      checkOutput("result", bus.result, mResult);
      checkOutput("rd_out", bus.rd_out, mRd);
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] rd);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    bus.rd_in   = rd;
    @(posedge clk);
    #2;
    bus.start   = 1'b0;
    bus.op      = 2'($urandom);
    bus.rs_data = 16'($urandom);
    bus.rt_data = 16'($urandom);
    bus.rd_in   = 4'($urandom);
  endtask

  task automatic waitDone(output int lat, output int busyCycles, output logic gotDone);
    lat = 0; busyCycles = 0; gotDone = 1'b0;
    for (int i = 0; i < 40 && !gotDone; i++) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busyCycles++;
      if (bus.done) gotDone = 1'b1;
    end
    checkOutput("doneSeen", gotDone, 1'b1);
  endtask

  task automatic runDirected(input string name, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] rd, input logic [15:0] expRes, input logic expErr, input int expLat);
    int   lat, busyC;
    logic got;
    applyStimulus(op, a, b, rd);
    waitDone(lat, busyC, got);
    checkOutput({name, "_result"}, bus.result, expRes);
    checkOutput({name, "_err"},    bus.err,    expErr);
    checkOutput({name, "_rd"},     bus.rd_out, rd);
    checkOutput({name, "_lat"},    lat,        expLat);
    checkOutput({name, "_busy"},   busyC,      expLat - 1);
  endtask

  initial begin
    int          lat, busyC, wrCount;
    logic        got, er, sp;
    logic [1:0]  op;
    logic [15:0] a, b, r;
    logic [3:0]  rd;

    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.rs_data = '0; bus.rt_data = '0; bus.rd_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",   bus.busy,   1'b0);
    checkOutput("rst_done",   bus.done,   1'b0);
    checkOutput("rst_wr",     bus.wr,     1'b0);
    checkOutput("rst_err",    bus.err,    1'b0);
    checkOutput("rst_result", bus.result, 16'h0000);
    checkOutput("rst_rd",     bus.rd_out, 4'h0);
    #1 rst = 1'b0;

    runDirected("mullo_1234", OP_MULLO, 16'h1234, 16'h0010, 4'd5, 16'h2340, 1'b0, 17);
    runDirected("mulhi_1234", OP_MULHI, 16'h1234, 16'h0010, 4'd6, 16'h0001, 1'b0, 17);
    runDirected("mulhi_ffff", OP_MULHI, 16'hFFFF, 16'hFFFF, 4'd7, 16'hFFFE, 1'b0, 17);
    runDirected("mullo_ffff", OP_MULLO, 16'hFFFF, 16'hFFFF, 4'd8, 16'h0001, 1'b0, 17);
    @(negedge clk);
    checkOutput("wr_single", bus.wr, 1'b0);
`ifdef MDU_DIV_EN
    runDirected("divq_100_7",  OP_DIVQ, 16'd100,  16'd7, 4'd1, 16'd14,   1'b0, 17);
    runDirected("divr_100_7",  OP_DIVR, 16'd100,  16'd7, 4'd2, 16'd2,    1'b0, 17);
    runDirected("divq_ffff_1", OP_DIVQ, 16'hFFFF, 16'd1, 4'd3, 16'hFFFF, 1'b0, 17);
    runDirected("divq_by0",    OP_DIVQ, 16'h0055, 16'd0, 4'd4, 16'hFFFF, 1'b1, 1);
    runDirected("divr_by0",    OP_DIVR, 16'h0055, 16'd0, 4'd9, 16'h0055, 1'b1, 1);
`else
    runDirected("divq_nodiv",  OP_DIVQ, 16'd100,  16'd7, 4'd1, 16'h0000, 1'b1, 1);
    runDirected("divr_nodiv",  OP_DIVR, 16'd100,  16'd7, 4'd2, 16'h0000, 1'b1, 1);
    runDirected("divq0_nodiv", OP_DIVQ, 16'h0055, 16'd0, 4'd4, 16'h0000, 1'b1, 1);
`endif
    runDirected("mullo_3x5", OP_MULLO, 16'd3, 16'd5, 4'd10, 16'h000F, 1'b0, 17);

    // Start and operand changes during RUN must not disturb the op in flight.
    applyStimulus(OP_MULLO, 16'h1234, 16'h0010, 4'd9);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVQ; bus.rs_data = 16'hFFFF; bus.rt_data = 16'h0003; bus.rd_in = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(lat, busyC, got);
    checkOutput("ignore_result", bus.result, 16'h2340);
    checkOutput("ignore_rd",     bus.rd_out, 4'd9);

    // Asynchronous reset in the middle of an iteration.
    @(negedge clk);
    applyStimulus(OP_MULLO, 16'hABCD, 16'h1234, 4'd3);
    repeat (8) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_busy",   bus.busy,   1'b0);
    checkOutput("midrst_done",   bus.done,   1'b0);
    checkOutput("midrst_wr",     bus.wr,     1'b0);
    checkOutput("midrst_result", bus.result, 16'h0000);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    wrCount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wr) wrCount++;
    end
    checkOutput("midrst_nowr", wrCount, 0);
    runDirected("after_rst_3x5", OP_MULLO, 16'd3, 16'd5, 4'd11, 16'h000F, 1'b0, 17);

    // Randomised ops, some back-to-back from the DONE cycle, some after idle gaps.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      rd = 4'($urandom);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      applyStimulus(op, a, b, rd);
      waitDone(lat, busyC, got);
      refOp(op, a, b, r, er, sp);
      checkOutput("rnd_result", bus.result, r);
      checkOutput("rnd_lat",    lat,        sp ? 1 : 17);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", totalCount, failCount);
    $finish;
  end

endmodule
